// File: rtl/seg_display_scanner.sv
// Multiplexed N-digit seven-segment driver with a sequential shift-add-3 BCD converter,
// hex mode, leading-zero blanking, overflow dashes, per-digit blink and decimal points.
module seg_display_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int VAL_WIDTH    = 16,
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [VAL_WIDTH-1:0]  val_in,
  input  logic                  val_valid,
  input  logic                  hex_mode,
  output logic                  busy,
  input  logic                  lz_blank,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic [NUM_DIGITS-1:0] blink_en,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int BCD_W   = 4 * NUM_DIGITS;
  localparam int PAD_W   = (VAL_WIDTH > BCD_W) ? VAL_WIDTH : BCD_W;
  localparam int CNT_W   = $clog2(VAL_WIDTH + 1);
  localparam int PRE_W   = $clog2(SCAN_DIV);
  localparam int PHASE_W = $clog2(2 * NUM_DIGITS);
  localparam int FRAME_W = $clog2(BLINK_FRAMES + 1);
  localparam int DIG_W   = $clog2(NUM_DIGITS);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t               state;
  logic [VAL_WIDTH-1:0] cap_val;
  logic                 cap_hex;
  logic [BCD_W-1:0]     bcd;
  logic [BCD_W-1:0]     bcd_adj;
  logic                 ovf_acc;
  logic [CNT_W-1:0]     bit_cnt;
  logic [BCD_W-1:0]     digits;
  logic                 overflow;
  logic [PAD_W-1:0]     cap_pad;
  logic [BCD_W-1:0]     hex_digits;
  logic                 hex_ovf;

  logic [PRE_W-1:0]     prescale;
  logic [PHASE_W-1:0]   phase;
  logic [FRAME_W-1:0]   frame_cnt;
  logic                 blink_phase;

  logic [3:0]           digit_arr [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lead_zero;
  logic [DIG_W-1:0]     sel;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [6:0]           seg_nxt;
  logic                 dp_nxt;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  // Add-3 correction is applied before the shift, so every nibble stays a legal BCD digit.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    cap_pad    = PAD_W'(cap_val);
    hex_digits = cap_pad[BCD_W-1:0];
    hex_ovf    = 1'b0;
    for (int i = BCD_W; i < PAD_W; i++) hex_ovf = hex_ovf | cap_pad[i];
  end

  // Digits and overflow only change in COMMIT, so the display never sees a half-converted value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      cap_val  <= '0;
      cap_hex  <= 1'b0;
      bcd      <= '0;
      ovf_acc  <= 1'b0;
      bit_cnt  <= '0;
      digits   <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (val_valid) begin
            cap_val <= val_in;
            cap_hex <= hex_mode;
            bcd     <= '0;
            ovf_acc <= 1'b0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= hex_mode ? COMMIT : CONV;
          end
        end
        CONV: begin
          bcd     <= {bcd_adj[BCD_W-2:0], cap_val[VAL_WIDTH-1]};
          cap_val <= cap_val << 1;
          ovf_acc <= ovf_acc | bcd_adj[BCD_W-1];
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(VAL_WIDTH - 1)) state <= COMMIT;
        end
        COMMIT: begin
          digits   <= cap_hex ? hex_digits : bcd;
          overflow <= cap_hex ? hex_ovf : ovf_acc;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prescale    <= '0;
      phase       <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (prescale == PRE_W'(SCAN_DIV - 1)) begin
      prescale <= '0;
      if (phase == PHASE_W'(2 * NUM_DIGITS - 1)) begin
        phase <= '0;
        if (frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FRAME_W'(1);
        end
      end else begin
        phase <= phase + PHASE_W'(1);
      end
    end else begin
      prescale <= prescale + PRE_W'(1);
    end
  end

  // A digit is a leading zero when it and every digit to its left are zero; digit 0 never is.
  always_comb begin
    logic run;
    run = 1'b1;
    lead_zero = '0;
    for (int i = 0; i < NUM_DIGITS; i++) digit_arr[i] = digits[4*i +: 4];
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      run = run && (digits[4*i +: 4] == 4'd0);
      lead_zero[i] = run;
    end
  end

  always_comb begin
    sel     = DIG_W'(NUM_DIGITS - 1) - DIG_W'(phase >> 1);
    an_nxt  = '1;
    seg_nxt = 7'h7F;
    dp_nxt  = 1'b1;
    if (phase[0]) begin
      an_nxt = ~(NUM_DIGITS'(1) << sel);
      if (overflow) begin
        seg_nxt = 7'h3F;
        dp_nxt  = ~dp_in[sel];
      end else if (blink_en[sel] && blink_phase) begin
        seg_nxt = 7'h7F;
      end else if (lz_blank && lead_zero[sel]) begin
        dp_nxt = ~dp_in[sel];
      end else begin
        seg_nxt = glyph(digit_arr[sel]);
        dp_nxt  = ~dp_in[sel];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      an  <= '1;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed bench for seg_display_scanner: table of loads with hand-decoded glyphs, plus
// scan-order, ignored-load, reset-abort and blink/decimal-point sequences.
module tb_seg_display_scanner;

  localparam int ND = 4;
  localparam int VW = 16;
  localparam int SD = 4;
  localparam int BF = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [VW-1:0] val_in;
  logic          val_valid;
  logic          hex_mode;
  logic          busy;
  logic          lz_blank;
  logic [ND-1:0] dp_in;
  logic [ND-1:0] blink_en;
  logic [ND-1:0] an;
  logic [6:0]    seg;
  logic          dp;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0]     val;
    logic            hex;
    logic            lz;
    logic [3:0]      dpi;
    logic [3:0][6:0] glyphs;
    logic [3:0]      dpn;
    int              busy_len;
  } vec_t;

  vec_t vecs [12];
  logic [3:0] scan_exp [8] = '{4'hF, 4'b1011, 4'hF, 4'b1101, 4'hF, 4'b1110, 4'hF, 4'b0111};

  seg_display_scanner #(
    .NUM_DIGITS(ND), .VAL_WIDTH(VW), .SCAN_DIV(SD), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .reset(reset), .val_in(val_in), .val_valid(val_valid),
    .hex_mode(hex_mode), .busy(busy), .lz_blank(lz_blank), .dp_in(dp_in),
    .blink_en(blink_en), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic wait_busy_count(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Waits for a fresh entry into digit d's phase so seg reflects current digit state.
  task automatic capture_digit(input int d, output logic [6:0] s, output logic p);
    logic [3:0] target;
    int n;
    target = ~(4'b0001 << d);
    n = 0;
    while (an === target && n < 200) begin @(negedge clk); n++; end
    while (an !== target && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      total++;
      bad++;
      $display("[TB] FAIL capture timeout digit %0d: got an=%0h expected %0h", d, an, target);
    end
    s = seg;
    p = dp;
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    int n;
    logic [6:0] s;
    logic p;
    lz_blank = v.lz;
    dp_in    = v.dpi;
    blink_en = '0;
    @(negedge clk);
    val_in    = v.val;
    hex_mode  = v.hex;
    val_valid = 1'b1;
    @(negedge clk);
    val_valid = 1'b0;
    wait_busy_count(n);
    checkOutput($sformatf("v%0d busy_len", idx), n, v.busy_len);
    for (int d = 3; d >= 0; d--) begin
      capture_digit(d, s, p);
      checkOutput($sformatf("v%0d seg%0d", idx, d), s, v.glyphs[d]);
      checkOutput($sformatf("v%0d dp%0d", idx, d), p, v.dpn[d]);
    end
  endtask

  initial begin
    logic [6:0] s;
    logic p;
    logic [3:0] cur;
    int n;
    int viol;
    int seen;
    int blanks;
    logic blank_f [8];

    reset = 1'b0; val_in = '0; val_valid = 1'b0; hex_mode = 1'b0;
    lz_blank = 1'b0; dp_in = '0; blink_en = '0;

    vecs[0]  = '{16'd1234,  1'b0, 1'b0, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111, 17};
    vecs[1]  = '{16'hBEEF,  1'b1, 1'b0, 4'b0000, {7'h03, 7'h06, 7'h06, 7'h0E}, 4'b1111, 1};
    vecs[2]  = '{16'd10000, 1'b0, 1'b0, 4'b0000, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b1111, 17};
    vecs[3]  = '{16'd42,    1'b0, 1'b0, 4'b0000, {7'h40, 7'h40, 7'h19, 7'h24}, 4'b1111, 17};
    vecs[4]  = '{16'd42,    1'b0, 1'b1, 4'b0000, {7'h7F, 7'h7F, 7'h19, 7'h24}, 4'b1111, 17};
    vecs[5]  = '{16'd5,     1'b0, 1'b1, 4'b0100, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'b1011, 17};
    vecs[6]  = '{16'h0000,  1'b1, 1'b1, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111, 1};
    vecs[7]  = '{16'd65535, 1'b0, 1'b0, 4'b0001, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b1110, 17};
    vecs[8]  = '{16'd9999,  1'b0, 1'b0, 4'b0000, {7'h10, 7'h10, 7'h10, 7'h10}, 4'b1111, 17};
    vecs[9]  = '{16'h00A0,  1'b1, 1'b1, 4'b0000, {7'h7F, 7'h7F, 7'h08, 7'h40}, 4'b1111, 1};
    vecs[10] = '{16'h1000,  1'b1, 1'b1, 4'b1000, {7'h79, 7'h40, 7'h40, 7'h40}, 4'b0111, 1};
    vecs[11] = '{16'd807,   1'b0, 1'b1, 4'b0000, {7'h7F, 7'h00, 7'h40, 7'h78}, 4'b1111, 17};

    // Reset held for three cycles, then released.
    repeat (3) @(negedge clk);
    checkOutput("reset an", an, 4'hF);
    checkOutput("reset seg", seg, 7'h7F);
    checkOutput("reset dp", dp, 1'b1);
    checkOutput("reset busy", busy, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("release an", an, 4'hF);
    checkOutput("release seg", seg, 7'h7F);
    checkOutput("release busy", busy, 1'b0);
    for (int d = 3; d >= 0; d--) begin
      capture_digit(d, s, p);
      checkOutput($sformatf("zero seg%0d", d), s, 7'h40);
      checkOutput($sformatf("zero dp%0d", d), p, 1'b1);
    end
    lz_blank = 1'b1;
    for (int d = 3; d >= 0; d--) begin
      capture_digit(d, s, p);
      checkOutput($sformatf("lz zero seg%0d", d), s, (d == 0) ? 7'h40 : 7'h7F);
    end
    lz_blank = 1'b0;

    // Scan order and dwell: each phase lasts SD cycles, blanks interleave digits.
    capture_digit(3, s, p);
    cur = an;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      while (an === cur && n < 50) begin @(negedge clk); n++; end
      checkOutput($sformatf("scan dwell %0d", i), n, SD);
      checkOutput($sformatf("scan an %0d", i), an, scan_exp[i]);
      if (scan_exp[i] == 4'hF) begin
        checkOutput($sformatf("scan blank seg %0d", i), seg, 7'h7F);
        checkOutput($sformatf("scan blank dp %0d", i), dp, 1'b1);
      end
      cur = an;
    end

    for (int i = 0; i < 12; i++) applyStimulus(i, vecs[i]);

    // A load request during conversion is dropped, not queued.
    lz_blank = 1'b0; dp_in = '0;
    @(negedge clk);
    val_in = 16'd1234; hex_mode = 1'b0; val_valid = 1'b1;
    @(negedge clk);
    val_valid = 1'b0;
    repeat (4) @(negedge clk);
    val_in = 16'd9999; val_valid = 1'b1;
    @(negedge clk);
    val_valid = 1'b0;
    wait_busy_count(n);
    checkOutput("noqueue busy_len", n, 12);
    repeat (3) @(negedge clk);
    checkOutput("noqueue idle", busy, 1'b0);
    for (int d = 3; d >= 0; d--) begin
      capture_digit(d, s, p);
      checkOutput($sformatf("noqueue seg%0d", d), s, vecs[0].glyphs[d]);
    end

    // Reset during the fifth conversion cycle aborts the load.
    @(negedge clk);
    val_in = 16'd5678; val_valid = 1'b1;
    @(negedge clk);
    val_valid = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("abort busy before", busy, 1'b1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    checkOutput("abort busy", busy, 1'b0);
    checkOutput("abort an", an, 4'hF);
    for (int d = 3; d >= 0; d--) begin
      capture_digit(d, s, p);
      checkOutput($sformatf("abort seg%0d", d), s, 7'h40);
    end
    @(negedge clk);
    checkOutput("abort stays idle", busy, 1'b0);

    // Blink on digit 0 with a period of 2 frames on / 2 off; dp only on digit 2.
    applyStimulus(0, vecs[0]);
    blink_en = 4'b0001;
    dp_in    = 4'b0100;
    blanks = 0;
    for (int f = 0; f < 8; f++) begin
      capture_digit(0, s, p);
      blank_f[f] = (s == 7'h7F);
      if (blank_f[f]) blanks++;
      checkOutput($sformatf("blink glyph f%0d", f), (s == 7'h7F) || (s == 7'h19), 1'b1);
    end
    checkOutput("blink blank count", blanks, 4);
    for (int f = 0; f < 6; f++)
      checkOutput($sformatf("blink period f%0d", f), blank_f[f] != blank_f[f+2], 1'b1);
    viol = 0;
    seen = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if ((dp === 1'b0) != (an === 4'b1011)) viol++;
      if (dp === 1'b0) seen++;
    end
    checkOutput("dp only digit2", viol, 0);
    checkOutput("dp digit2 lit", seen > 0, 1'b1);
    capture_digit(1, s, p);
    checkOutput("no blink digit1", s, 7'h30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
